// File: rtl/axis_keep_downsizer.sv
// AXI-Stream width downsizer: holds one wide word and emits its narrow segments
// in ascending order, skipping every segment whose tkeep bits are all zero.
module axis_keep_downsizer #(
    parameter int INPUT_DATA_WIDTH  = 64,
    parameter int OUTPUT_DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0]    input_axis_tdata,
    input  logic [INPUT_DATA_WIDTH/8-1:0]  input_axis_tkeep,
    input  logic                           input_axis_tvalid,
    output logic                           input_axis_tready,
    input  logic                           input_axis_tlast,
    input  logic                           input_axis_tuser,
    output logic [OUTPUT_DATA_WIDTH-1:0]   output_axis_tdata,
    output logic [OUTPUT_DATA_WIDTH/8-1:0] output_axis_tkeep,
    output logic                           output_axis_tvalid,
    input  logic                           output_axis_tready,
    output logic                           output_axis_tlast,
    output logic                           output_axis_tuser
);
    localparam int INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8;
    localparam int OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8;
    localparam int SEG_COUNT         = INPUT_DATA_WIDTH / OUTPUT_DATA_WIDTH;
    localparam int IDX_W             = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

    typedef enum logic {EMPTY, SEND} state_t;

    state_t                      state_q, state_d;
    logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
    logic [INPUT_KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                        last_q, last_d;
    logic                        user_q, user_d;
    logic [IDX_W-1:0]            seg_idx_q, seg_idx_d;
    logic [IDX_W-1:0]            last_idx_q, last_idx_d;
    logic                        rdy_en_q, rdy_en_d;

    logic [SEG_COUNT-1:0] in_live;
    logic [SEG_COUNT-1:0] held_live;
    logic [IDX_W-1:0]     in_first;
    logic [IDX_W-1:0]     in_last;
    logic [IDX_W-1:0]     held_next;
    logic                 out_hs;
    logic                 final_hs;
    logic                 in_hs;

    // Segment liveness and the lowest/highest/next live segment lookups.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_live   = '0;
        held_live = '0;
        in_first  = '0;
        in_last   = '0;
        held_next = last_idx_q;
        for (int i = 0; i < SEG_COUNT; i++) begin
            in_live[i]   = |input_axis_tkeep[i*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH];
            held_live[i] = |keep_q[i*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH];
        end
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (in_live[i]) in_last = IDX_W'(i);
        end
        for (int i = SEG_COUNT - 1; i >= 0; i--) begin
            if (in_live[i]) in_first = IDX_W'(i);
            if (held_live[i] && (i > int'(seg_idx_q))) held_next = IDX_W'(i);
        end
    end

    assign output_axis_tvalid = (state_q == SEND);
    assign output_axis_tdata  = data_q[int'(seg_idx_q)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
    assign output_axis_tkeep  = keep_q[int'(seg_idx_q)*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH];
    assign output_axis_tlast  = last_q & (seg_idx_q == last_idx_q);
    assign output_axis_tuser  = user_q & last_q & (seg_idx_q == last_idx_q);

    assign out_hs   = output_axis_tvalid & output_axis_tready;
    assign final_hs = out_hs & (seg_idx_q == last_idx_q);
    // rdy_en_q keeps tready low during reset and for the first edge after it.
    assign input_axis_tready = rdy_en_q & ((state_q == EMPTY) | final_hs);
    assign in_hs             = input_axis_tready & input_axis_tvalid;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        user_d     = user_q;
        seg_idx_d  = seg_idx_q;
        last_idx_d = last_idx_q;
        rdy_en_d   = 1'b1;

        if (out_hs && !final_hs) seg_idx_d = held_next;
        if (final_hs)            state_d   = EMPTY;

        // A zero-keep word is only emitted when it carries tlast; it then
        // shows up as a single segment-0 beat with tkeep = 0.
        if (in_hs) begin
            data_d     = input_axis_tdata;
            keep_d     = input_axis_tkeep;
            last_d     = input_axis_tlast;
            user_d     = input_axis_tuser;
            seg_idx_d  = in_first;
            last_idx_d = in_last;
            state_d    = ((|in_live) || input_axis_tlast) ? SEND : EMPTY;
        end
    end

    // NOTE: the held word is reset too, so outputs read as zero during reset
    // and no stale data from an aborted frame survives release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            user_q     <= 1'b0;
            seg_idx_q  <= '0;
            last_idx_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            user_q     <= user_d;
            seg_idx_q  <= seg_idx_d;
            last_idx_q <= last_idx_d;
            rdy_en_q   <= rdy_en_d;
        end
    end
endmodule

// File: doc/axis_keep_downsizer.md
AXIS_KEEP_DOWNSIZER -- requirements
Module: axis_keep_downsizer

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 64: input tdata width in bits.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 8: output tdata width in bits.
REQ-003 SHALL derive INPUT_KEEP_WIDTH = INPUT_DATA_WIDTH/8 and OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH/8, and SEG_COUNT = INPUT_DATA_WIDTH/OUTPUT_DATA_WIDTH (integer, >= 1); other ratios are illegal.
REQ-004 SHALL have ports as follows:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- input_axis_tdata  in  INPUT_DATA_WIDTH  wide data word.
- input_axis_tkeep  in  INPUT_KEEP_WIDTH  byte enables.
- input_axis_tvalid  in  1  input word valid.
- input_axis_tready  out  1  input word accepted when high with tvalid.
- input_axis_tlast  in  1  last word of frame.
- input_axis_tuser  in  1  frame error/user flag.
- output_axis_tdata  out  OUTPUT_DATA_WIDTH  narrow segment.
- output_axis_tkeep  out  OUTPUT_KEEP_WIDTH  segment byte enables.
- output_axis_tvalid  out  1  segment valid.
- output_axis_tready  in  1  downstream ready.
- output_axis_tlast  out  1  last segment of frame.
- output_axis_tuser  out  1  user flag, last segment only.

Function
REQ-005 SHALL split input segment i as tdata bits [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] with tkeep bits [i*OUTPUT_KEEP_WIDTH +: OUTPUT_KEEP_WIDTH], emitted in ascending i.
REQ-006 SHALL define a segment as "live" when any of its tkeep bits is 1; non-live segments SHALL never be emitted, except as in REQ-012.
REQ-007 SHALL hold one input word in registers, with a two-state FSM: EMPTY (no word held) and SEND (word held).
REQ-008 SHALL assert input_axis_tready in EMPTY, and in SEND only in the cycle where the final live segment handshakes (output_axis_tvalid & output_axis_tready & seg_idx == last_idx).
REQ-009 SHALL, on an input handshake: capture data/keep/last/user; set seg_idx to the lowest live segment and last_idx to the highest live segment; go to SEND. The first output beat SHALL be valid the cycle after the input handshake (latency 1).
REQ-010 SHALL drive output_axis_tvalid = (state == SEND) only, and drive tdata/tkeep from segment seg_idx of the held word; outputs SHALL stay stable while tvalid & !tready.
REQ-011 SHALL, on an output handshake with seg_idx != last_idx, advance seg_idx to the next live segment above it in one cycle, skipping any number of non-live segments.
REQ-012 SHALL treat an accepted word whose tkeep is all zero as follows: if tlast = 0, consume it and emit nothing (remain/return to EMPTY); if tlast = 1, emit one beat from segment 0 with tkeep = 0, tlast = 1, tuser = captured tuser.
REQ-013 SHALL assert output_axis_tlast = held_last & (seg_idx == last_idx); it SHALL never be asserted on any earlier segment.
REQ-014 SHALL assert output_axis_tuser = held_user & held_last & (seg_idx == last_idx), else 0.
REQ-015 SHALL, when the final segment handshakes and input_axis_tvalid is high in the same cycle, load the new word and remain in SEND (zero-bubble back-to-back); if input is not valid, return to EMPTY.
REQ-016 SHALL, for SEG_COUNT = 1, act as a one-register stage passing tkeep unchanged, applying REQ-012 to zero-keep words.
REQ-017 SHALL use no combinational path from input_axis_tvalid to output_axis_tvalid or from output_axis_tready to output data.

Reset
REQ-018 SHALL, while rst_n is low, asynchronously force state to EMPTY and all held registers, seg_idx and last_idx to 0.
REQ-019 SHALL hold input_axis_tready = 0 and output_axis_tvalid/tlast/tuser/tdata/tkeep = 0 while rst_n is low; input_axis_tready SHALL be 1 from the first clk edge after release.
REQ-020 SHALL discard any held word when reset is asserted mid-frame, with no partial beat emitted after release.

Verification
REQ-021 SHALL pass: tdata 64'habcdabcdabcdabcd, tkeep 8'h1F, tlast 1, output_axis_tready 1 -> five beats cd,ab,cd,ab,cd with tkeep 1; tlast only on the 5th; input_axis_tready low for 4 cycles.
REQ-022 SHALL pass: tkeep 8'b10000001, tdata 64'h11223344556677EE, tlast 1 -> exactly two beats EE then 11, tlast on 11, in consecutive cycles.
REQ-023 SHALL pass: two back-to-back full words (tkeep 8'hFF, tlast 0 then 1), output_axis_tready toggling 1,0 -> 16 beats in byte order, no beat lost or duplicated, tlast only on beat 16, data stable during stalls.
REQ-024 SHALL pass: tkeep 8'h00 with tlast 0 -> no output beat; tkeep 8'h00 with tlast 1, tuser 1 -> one beat, tkeep 0, tlast 1, tuser 1.
REQ-025 SHALL pass: rst_n pulled low after the 3rd of 8 beats -> tvalid drops to 0 asynchronously; after release, no further beats, input_axis_tready = 1.
REQ-026 SHALL pass: SEG_COUNT = 1 instance (64->64) with tkeep 8'h0F, tlast 1 -> one beat, same data and tkeep, latency 1 cycle.
